// File: rtl/lcd_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : lcd_cmd_seq
// Purpose  : Host command FIFO and one-at-a-time issue sequencer for the LCD
//            image controller; optional busy-rise timeout via LCD_CMD_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module lcd_cmd_seq #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] host_cmd,
    input  logic       host_valid,
    output logic       host_ready,
    input  logic       lcd_busy,
    input  logic       lcd_done,
    output logic [3:0] cmd,
    output logic       cmd_valid,
    output logic [4:0] fifo_cnt,
    output logic       err_illegal,
    output logic       err_timeout,
    output logic       seq_done
);

    localparam int              AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]   c_PTR_ONE   = AW'(1);
    localparam logic [4:0]      c_DEPTH     = 5'(DEPTH);
    localparam logic [3:0]      c_MAX_LEGAL = 4'd11;

    generate
        if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("lcd_cmd_seq: DEPTH must be a power of two in 2..16");
        end
        if ((TIMEOUT < 1) || (TIMEOUT > 15)) begin : g_bad_timeout
            $error("lcd_cmd_seq: TIMEOUT must be in 1..15");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [4:0]    r_cnt;
    logic          r_host_ready;
    logic [3:0]    r_cmd;
    logic          r_cmd_valid;
    logic          r_err_illegal;
    logic          r_err_timeout;
    logic          r_seq_done;

    logic          w_push_en;
    logic          w_push;
    logic          w_illegal;
    logic          w_pop;
    logic          w_timeout;
    logic [4:0]    w_cnt_nxt;
    logic          w_seq_done_nxt;
    logic          w_ready_nxt;

    assign w_push_en      = host_valid && r_host_ready;
    assign w_push         = w_push_en && (host_cmd <= c_MAX_LEGAL);
    assign w_illegal      = w_push_en && (host_cmd > c_MAX_LEGAL);
    assign w_cnt_nxt      = r_cnt + {4'd0, w_push} - {4'd0, w_pop};
    assign w_seq_done_nxt = r_seq_done || ((r_state == S_FINISH) && lcd_done);
    // Ready is registered, so it is computed from next-cycle values.
    assign w_ready_nxt    = (w_cnt_nxt != c_DEPTH) && (w_state_nxt != S_FINISH)
                            && !w_seq_done_nxt;

`ifdef LCD_CMD_TIMEOUT_EN
    localparam logic [3:0] c_TO_LAST = 4'(TIMEOUT - 1);
    logic [3:0] r_to_cnt;

    assign w_timeout = (r_state == S_WAIT_HI) && !lcd_busy && (r_to_cnt == c_TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt <= 4'd0;
        end else if (r_state != S_WAIT_HI) begin
            r_to_cnt <= 4'd0;
        end else if (!lcd_busy) begin
            r_to_cnt <= r_to_cnt + 4'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_cnt != 5'd0) && !lcd_busy && !r_seq_done) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE:   w_state_nxt = S_WAIT_HI;
            S_WAIT_HI: begin
                if (lcd_busy) begin
                    w_state_nxt = S_WAIT_LO;
                end else if (w_timeout) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_WAIT_LO: begin
                // The write command closes the sequence.
                if (!lcd_busy) begin
                    w_state_nxt = (r_cmd == 4'd0) ? S_FINISH : S_IDLE;
                end
            end
            S_FINISH: begin
                if (lcd_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_cnt         <= 5'd0;
            r_host_ready  <= 1'b0;
            r_cmd         <= 4'd0;
            r_cmd_valid   <= 1'b0;
            r_err_illegal <= 1'b0;
            r_err_timeout <= 1'b0;
            r_seq_done    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_host_ready  <= w_ready_nxt;
            r_err_illegal <= w_illegal;
            r_seq_done    <= w_seq_done_nxt;
            r_cmd_valid   <= (w_state_nxt == S_ISSUE);
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
                r_cmd  <= r_mem[r_rptr];
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= host_cmd;
        end
    end

    assign host_ready  = r_host_ready;
    assign cmd         = r_cmd;
    assign cmd_valid   = r_cmd_valid;
    assign fifo_cnt    = r_cnt;
    assign err_illegal = r_err_illegal;
    assign err_timeout = r_err_timeout;
    assign seq_done    = r_seq_done;

endmodule
`default_nettype wire

// File: doc/lcd_cmd_seq.md
Name: lcd_cmd_seq

Overview:
- Command sequencer directly upstream of the LCD image controller.
- Buffers host commands in a small FIFO and checks each code.
- Issues one command at a time on the controller's cmd/cmd_valid interface and paces the next issue on the controller's busy signal.
- Treats the write command (code 0) as the end of a sequence and reports completion when the controller signals done.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of two, 2..16.
- TIMEOUT, 15, cycles to wait for busy to rise before a retry; used only with the optional feature.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  reset.
- host_cmd  input  4  command code from the host: 0 write, 1-4 up/down/left/right, 5 max, 6 min, 7 avg, 8 ccrotate, 9 crotate, 10 mirrorx, 11 mirrory.
- host_valid  input  1  host_cmd is valid this cycle.
- host_ready  output  1  a push is accepted this cycle.
- lcd_busy  input  1  busy from the LCD controller.
- lcd_done  input  1  done from the LCD controller.
- cmd  output  4  command to the controller.
- cmd_valid  output  1  issue strobe to the controller.
- fifo_cnt  output  5  current FIFO occupancy, 0..DEPTH.
- err_illegal  output  1  one-cycle pulse when an illegal code is dropped.
- err_timeout  output  1  sticky retry flag.
- seq_done  output  1  sticky: the sequence has completed.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low. The port is named reset and asserts at 0.
- Reset values: host_ready=0, cmd=0, cmd_valid=0, fifo_cnt=0, err_illegal=0, err_timeout=0, seq_done=0. FIFO pointers are 0 and the state is IDLE.
  - host_ready becomes 1 on the first clock after reset is released.
  - Reset asserted mid-operation aborts everything immediately and discards FIFO contents.
- host_ready = (fifo_cnt != DEPTH) and state != FINISH and seq_done == 0. All outputs are registered.
- Push: happens when host_valid and host_ready are both 1.
  - Codes 12-15 are not stored; err_illegal pulses high on the next cycle.
  - Codes 0-11 are written at the write pointer; fifo_cnt increments.
- Full FIFO: a push is refused even if a pop occurs in the same cycle.
- Empty FIFO: a word pushed this cycle can be issued no earlier than the next cycle.
- Simultaneous legal push and pop: fifo_cnt is unchanged. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- States and transitions:
  - IDLE: if fifo_cnt>0 and lcd_busy==0, pop the head into cmd and set cmd_valid=1 on the next edge; go to ISSUE.
  - ISSUE: lasts exactly one cycle with cmd_valid=1, then cmd_valid=0; go to WAIT_HI.
  - WAIT_HI: wait for lcd_busy==1, then go to WAIT_LO.
  - WAIT_LO: wait for lcd_busy==0.
    - If the issued cmd was 0, go to FINISH.
    - Otherwise go to IDLE.
    - Minimum spacing between two issues is 4 cycles.
  - FINISH: wait for lcd_done==1; then seq_done=1 (sticky until reset) and return to IDLE with pushes blocked. Remaining FIFO entries are never issued.
- cmd holds its value from ISSUE until the next pop, so the controller may sample it in any cycle while busy.
- lcd_busy already high in IDLE (controller image load after reset): no issue occurs; the queue accumulates.
- lcd_done seen outside FINISH is ignored.

Optional Feature:
- Macro: LCD_CMD_TIMEOUT_EN.
- Defined: a 4-bit counter runs in WAIT_HI.
  - If lcd_busy is still 0 after TIMEOUT cycles, re-enter ISSUE with the same cmd (cmd_valid pulses again) and set err_timeout=1 (sticky).
  - The counter clears on each ISSUE.
- Not defined: no counter; WAIT_HI waits indefinitely and err_timeout is tied to 0.

Test Plan:
- Reset low, then high with lcd_busy=1 for 70 cycles; push 5,3 → no cmd_valid while busy. After busy falls, cmd_valid pulses with cmd=5, then cmd=3 after the busy high-low cycle. fifo_cnt goes 2,1,0.
- Push code 13 → err_illegal pulses one cycle, fifo_cnt unchanged, nothing is issued.
- Hold lcd_busy=1 and push 8 commands → host_ready=0 at fifo_cnt=8. A 9th push is refused even in the cycle the first pop occurs.
- Push 9,0,4; controller model toggles busy, then asserts lcd_done 64 cycles after the write → cmd 9, then 0, are issued; seq_done=1; cmd 4 is never issued; host_ready stays 0.
- Assert reset low while in WAIT_LO with 3 entries queued → all outputs return to reset values and fifo_cnt=0.
- With LCD_CMD_TIMEOUT_EN, controller model ignores the first strobe → after 15 cycles cmd_valid re-pulses with the same cmd and err_timeout=1.
